// File: rtl/dp_ram_clr_if.sv
// Bus bundle for dp_ram_clr: clear control, byte-enabled write port and
// registered read port.
interface dp_ram_clr_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic            clr_req;
  logic            busy;
  logic            clr_done;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wbe;
  logic            re;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata;
  logic            rvalid;

  modport master (
    output clr_req, we, waddr, wdata, wbe, re, raddr,
    input  busy, clr_done, rdata, rvalid
  );

  modport slave (
    input  clr_req, we, waddr, wdata, wbe, re, raddr,
    output busy, clr_done, rdata, rvalid
  );
endinterface

// File: rtl/dp_ram_clr.sv
// Simple dual-port RAM with byte enables and a sequential clear engine that
// owns the array for 2**AW cycles after reset or a clear request.
module dp_ram_clr #(
  parameter int            DW      = 16,
  parameter int            AW      = 8,
  parameter bit            RDW_NEW = 1'b0,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  dp_ram_clr_if.slave bus
);
  localparam int            NB        = DW / 8;
  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_clr_cnt;
  logic [AW-1:0]   w_clr_cnt_next;
  logic            w_busy;
  logic            w_clr_done;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [DW-1:0]   w_rd_word;
  logic [DW-1:0]   r_rdata;
  logic            r_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_busy         = 1'b0;
    w_clr_done     = 1'b0;
    w_wr_acc       = 1'b0;
    w_rd_acc       = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_cnt == LAST_ADDR) begin
          // Last word written this cycle; park the counter instead of wrapping.
          w_clr_done     = 1'b1;
          w_state_next   = ST_READY;
          w_clr_cnt_next = '0;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      default: begin
        w_wr_acc = bus.we;
        w_rd_acc = bus.re;
        if (bus.clr_req) begin
          w_state_next   = ST_CLEAR;
          w_clr_cnt_next = '0;
        end
      end
    endcase
  end

  // One narrow array per byte lane so byte enables map onto plain writes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic       w_hit;

    always_ff @(posedge clk) begin
      if (w_busy) begin
        r_mem[r_clr_cnt] <= CLR_VAL[8*gi +: 8];
      end else if (w_wr_acc && bus.wbe[gi]) begin
        r_mem[bus.waddr] <= bus.wdata[8*gi +: 8];
      end
    end

    assign w_hit = RDW_NEW && w_wr_acc && bus.wbe[gi] && (bus.waddr == bus.raddr);
    assign w_rd_word[8*gi +: 8] = w_hit ? bus.wdata[8*gi +: 8] : r_mem[bus.raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.clr_done = w_clr_done;
  assign bus.rdata    = r_rdata;
  assign bus.rvalid   = r_rvalid;
endmodule

// File: tb/tb_dp_ram_clr.sv
// Three dp_ram_clr instances (old-data, new-data, 8-bit/16-deep with 0xFF
// clear) driven by shared stimulus and checked against an array model.
module tb_dp_ram_clr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_clr_req, s_we, s_re;
  logic [7:0]  s_waddr, s_raddr;
  logic [15:0] s_wdata;
  logic [1:0]  s_wbe;

  dp_ram_clr_if #(.DW(16), .AW(8)) if0 ();
  dp_ram_clr_if #(.DW(16), .AW(8)) if1 ();
  dp_ram_clr_if #(.DW(8),  .AW(4)) if2 ();

  assign if0.clr_req = s_clr_req; assign if1.clr_req = s_clr_req; assign if2.clr_req = s_clr_req;
  assign if0.we = s_we;           assign if1.we = s_we;           assign if2.we = s_we;
  assign if0.re = s_re;           assign if1.re = s_re;           assign if2.re = s_re;
  assign if0.waddr = s_waddr;     assign if1.waddr = s_waddr;     assign if2.waddr = s_waddr[3:0];
  assign if0.raddr = s_raddr;     assign if1.raddr = s_raddr;     assign if2.raddr = s_raddr[3:0];
  assign if0.wdata = s_wdata;     assign if1.wdata = s_wdata;     assign if2.wdata = s_wdata[7:0];
  assign if0.wbe = s_wbe;         assign if1.wbe = s_wbe;         assign if2.wbe = s_wbe[0];

  dp_ram_clr #(.DW(16), .AW(8), .RDW_NEW(1'b0), .CLR_VAL(16'h0000))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  dp_ram_clr #(.DW(16), .AW(8), .RDW_NEW(1'b1), .CLR_VAL(16'h0000))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  dp_ram_clr #(.DW(8), .AW(4), .RDW_NEW(1'b0), .CLR_VAL(8'hFF))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Reference model: per-instance word arrays plus remaining clear cycles.
  int          depth [3] = '{256, 256, 16};
  int          nbytes[3] = '{2, 2, 1};
  bit          rdw   [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] clrv  [3] = '{16'h0000, 16'h0000, 16'h00FF};
  logic [15:0] mdl   [3][256];
  int          left  [3];
  logic [15:0] q0[$], q1[$], q2[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic busy_of(input int k);
    case (k) 0: return if0.busy; 1: return if1.busy; default: return if2.busy; endcase
  endfunction
  function automatic logic done_of(input int k);
    case (k) 0: return if0.clr_done; 1: return if1.clr_done; default: return if2.clr_done; endcase
  endfunction
  function automatic logic rv_of(input int k);
    case (k) 0: return if0.rvalid; 1: return if1.rvalid; default: return if2.rvalid; endcase
  endfunction
  function automatic logic [15:0] rd_of(input int k);
    case (k) 0: return if0.rdata; 1: return if1.rdata; default: return {8'h00, if2.rdata}; endcase
  endfunction
  function automatic int qsize(input int k);
    case (k) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  function automatic void qpush(input int k, input logic [15:0] v);
    case (k) 0: q0.push_back(v); 1: q1.push_back(v); default: q2.push_back(v); endcase
  endfunction
  function automatic logic [15:0] qpop(input int k);
    case (k) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
  endfunction

  function automatic void fill_clear(input int k);
    left[k] = depth[k];
    for (int a = 0; a < depth[k]; a++) mdl[k][a] = clrv[k];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) fill_clear(k);
    q0.delete(); q1.delete(); q2.delete();
  endfunction

  // Check the current cycle's combinational outputs, advance the model over
  // the coming rising edge, then return at the following falling edge.
  task automatic tick();
    int          wa, ra;
    logic [15:0] pre;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy%0d", k), {15'h0, busy_of(k)}, {15'h0, (!rst_n) || (left[k] > 0)});
      chk($sformatf("clr_done%0d", k), {15'h0, done_of(k)}, {15'h0, rst_n && (left[k] == 1)});
      if (!rst_n) begin
        chk($sformatf("rst_rvalid%0d", k), {15'h0, rv_of(k)}, 16'h0);
        chk($sformatf("rst_rdata%0d", k), rd_of(k), 16'h0);
        continue;
      end
      if (left[k] > 0) begin
        left[k]--;
        continue;
      end
      wa  = int'(s_waddr) % depth[k];
      ra  = int'(s_raddr) % depth[k];
      pre = mdl[k][ra];
      if (s_we)
        for (int b = 0; b < nbytes[k]; b++)
          if (s_wbe[b]) mdl[k][wa][8*b +: 8] = s_wdata[8*b +: 8];
      if (s_re) qpush(k, rdw[k] ? mdl[k][ra] : pre);
      if (s_clr_req) fill_clear(k);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        if (rv_of(k)) begin
          if (qsize(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid%0d: got 1 expected 0 (no read accepted) at %0t", k, $time);
          end else begin
            chk($sformatf("rdata%0d", k), rd_of(k), qpop(k));
          end
        end
      end
    end
  end

  task automatic idle();
    s_clr_req = 1'b0; s_we = 1'b0; s_re = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    idle(); s_we = 1'b1; s_waddr = a; s_wdata = d; s_wbe = be; tick();
  endtask

  task automatic rd(input logic [7:0] a);
    idle(); s_re = 1'b1; s_raddr = a; tick();
  endtask

  task automatic async_reset_check(input string tag);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_busy%0d", tag, k), {15'h0, busy_of(k)}, 16'h1);
      chk($sformatf("%s_done%0d", tag, k), {15'h0, done_of(k)}, 16'h0);
      chk($sformatf("%s_rvalid%0d", tag, k), {15'h0, rv_of(k)}, 16'h0);
      chk($sformatf("%s_rdata%0d", tag, k), rd_of(k), 16'h0);
    end
    model_reset();
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    idle(); s_waddr = '0; s_raddr = '0; s_wdata = '0; s_wbe = '0;
    model_reset();
    @(negedge clk);
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Initial clear, then sweep every address.
    for (int i = 0; i < 256; i++) tick();
    for (int a = 0; a < 256; a++) rd(8'(a));
    idle(); tick();

    // Byte-enable merge.
    wr(8'h05, 16'h1234, 2'b11);
    wr(8'h05, 16'hAB00, 2'b10);
    wr(8'h06, 16'hFFFF, 2'b00);
    rd(8'h05);
    idle(); tick();
    chk("merge_rdata0", if0.rdata, 16'hAB34);
    chk("merge_rvalid_drop0", {15'h0, if0.rvalid}, 16'h0);
    rd(8'h06);

    // Read-during-write to the same address.
    wr(8'h07, 16'h1111, 2'b11);
    idle(); s_we = 1'b1; s_re = 1'b1; s_waddr = 8'h07; s_raddr = 8'h07;
    s_wdata = 16'h2222; s_wbe = 2'b11; tick();
    idle(); tick();
    chk("rdw_old0", if0.rdata, 16'h1111);
    chk("rdw_new1", if1.rdata, 16'h2222);

    // Clear request; traffic during busy must be ignored.
    wr(8'h10, 16'h5A5A, 2'b11);
    idle(); s_clr_req = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin
      s_clr_req = 1'($urandom_range(0, 1));
      s_we = 1'b1; s_re = 1'b1; s_waddr = 8'h10; s_raddr = 8'h10;
      s_wdata = 16'($urandom); s_wbe = 2'b11;
      tick();
    end
    idle();
    guard = 0;
    while (left[0] > 0 && guard < 400) begin tick(); guard++; end
    chk("clear_timeout", 16'(guard < 400), 16'h1);
    rd(8'h10);
    idle(); tick();
    chk("clear_rdata0", if0.rdata, 16'h0000);

    // Reset while read data is being presented.
    wr(8'h03, 16'hC3C3, 2'b11);
    rd(8'h03);
    async_reset_check("rdpend");
    for (int i = 0; i < 256; i++) tick();

    // Reset in the middle of a clear: full-length clear afterwards.
    idle(); s_clr_req = 1'b1; tick();
    idle();
    for (int i = 0; i < 128; i++) tick();
    async_reset_check("midclr");
    for (int i = 0; i < 256; i++) tick();
    for (int a = 0; a < 16; a++) rd(8'(a));

    // Random traffic over a small address window to force collisions.
    for (int i = 0; i < 1500; i++) begin
      s_we      = 1'($urandom_range(0, 1));
      s_re      = 1'($urandom_range(0, 1));
      s_waddr   = 8'($urandom_range(0, 31));
      s_raddr   = 8'($urandom_range(0, 31));
      s_wdata   = 16'($urandom);
      s_wbe     = 2'($urandom);
      s_clr_req = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle();
    tick(); tick();
    for (int k = 0; k < 3; k++)
      chk($sformatf("pending_reads%0d", k), 16'(qsize(k)), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dp_ram_clr.md
DP_RAM_CLR -- requirements
Module: dp_ram_clr

Interface
REQ-001 Parameter DW, default 16, data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter AW, default 8, address width; depth = 2**AW words.
REQ-003 Parameter RDW_NEW, default 0, read-during-write mode: 0 = old data, 1 = new data.
REQ-004 Parameter CLR_VAL, default 0, DW-bit value written to every word by the clear engine.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clr_req  input  1  request a full-memory clear; sampled only in state READY.
REQ-008 busy  output  1  high while the clear engine owns the array.
REQ-009 clr_done  output  1  one-cycle pulse on the last clear write.
REQ-010 we  input  1  write strobe.
REQ-011 waddr  input  AW  write address.
REQ-012 wdata  input  DW  write data.
REQ-013 wbe  input  DW/8  byte enables; bit i gates wdata[8i+7:8i].
REQ-014 re  input  1  read strobe.
REQ-015 raddr  input  AW  read address.
REQ-016 rdata  output  DW  registered read data.
REQ-017 rvalid  output  1  high the cycle after an accepted read.

Function
REQ-018 FSM states: CLEAR and READY only.
REQ-019 In CLEAR, each cycle writes CLR_VAL to address clr_cnt, then increments clr_cnt by 1.
REQ-020 CLEAR -> READY when clr_cnt = 2**AW-1 has been written; clr_done pulses high in that same cycle, so a clear takes exactly 2**AW cycles.
REQ-021 READY -> CLEAR when clr_req = 1; clr_cnt loads 0 and the first clear write occurs in the next cycle.
REQ-022 busy = 1 in CLEAR and 0 in READY.
REQ-023 A user write is accepted when we = 1 and state is READY; the word at waddr updates only in bytes whose wbe bit is 1, other bytes are unchanged.
REQ-024 we = 1 with wbe = 0 leaves the array unchanged.
REQ-025 A user read is accepted when re = 1 and state is READY; rdata takes mem[raddr] on the next rising edge and rvalid = 1 for that one cycle.
REQ-026 When no read is accepted, rdata holds its previous value and rvalid = 0.
REQ-027 Read and write are accepted in the same cycle; at different addresses they are independent.
REQ-028 Read and write to the same address: with RDW_NEW = 0, rdata returns the pre-write word; with RDW_NEW = 1, rdata returns the byte-merged post-write word.
REQ-029 we and re in CLEAR are ignored: no array change, and rvalid stays 0.
REQ-030 clr_req asserted in CLEAR is ignored; the clear in progress is not restarted.
REQ-031 clr_req and we are both asserted in READY: the write is accepted, and the clear that starts next cycle overwrites it.
REQ-032 clr_cnt is AW bits wide and SHALL NOT wrap into a second pass.

Reset
REQ-033 rst_n = 0 forces state CLEAR, clr_cnt = 0, busy = 1, clr_done = 0, rdata = 0, rvalid = 0, asynchronously.
REQ-034 The array contents are not reset directly; they are cleared by the engine starting on the first clock edge after rst_n rises.
REQ-035 rst_n asserted mid-clear aborts the clear; the next clear restarts at address 0.
REQ-036 rst_n asserted with a read pending drops rvalid to 0 immediately.

Verification
REQ-037 Release reset, count cycles -> busy high for exactly 256 cycles, clr_done pulses once, then read all addresses -> every word 0x0000 (default parameters).
REQ-038 Write 0x1234 to address 0x05 with wbe = 2'b11, then write 0xAB00 with wbe = 2'b10, then read 0x05 -> rdata = 0xAB34, rvalid high for one cycle.
REQ-039 Address 0x07 holds 0x1111; write 0x2222 to it and read it in the same cycle -> rdata = 0x1111 with RDW_NEW = 0, and 0x2222 with RDW_NEW = 1.
REQ-040 Write 0x5A5A to 0x10, then pulse clr_req, and issue we/re during busy -> rvalid stays 0; after clr_done, a read of 0x10 -> 0x0000.
REQ-041 Assert rst_n = 0 while clr_cnt = 0x80 -> busy stays 1, outputs go to reset values; after release, busy stays high for a full 256 cycles.
REQ-042 Instantiate with DW = 8, AW = 4, CLR_VAL = 0xFF -> clear lasts 16 cycles and every word reads 0xFF.
